// File: rtl/mult_core.sv
// mult_core: sequential radix-2 shift-add multiplier.
// It serves the HPS multiplier conduits. A rising edge on m_start[0] captures
// the operands. The engine then processes one multiplier bit per clock. The
// result and the status flags appear DATA_W edges after the capture.
//
// Ports:
//   clk_clk        in   system clock
//   reset_reset_n  in   asynchronous active-low reset
//   m_start        in   CTRL_W  bit0 = start request level (rising edge launches)
//   m_reset        in   CTRL_W  bit0 = synchronous soft clear
//   m_in1          in   DATA_W  multiplicand
//   m_in2          in   DATA_W  multiplier
//   m_result       out  DATA_W  low half of the product, registered
//   m_done         out  CTRL_W  bit0 done, bit1 overflow, bit2 busy, rest 0
module mult_core #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 32,
  parameter int SIGNED = 0
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [CTRL_W-1:0] m_start,
  input  logic [CTRL_W-1:0] m_reset,
  input  logic [DATA_W-1:0] m_in1,
  input  logic [DATA_W-1:0] m_in2,
  output logic [DATA_W-1:0] m_result,
  output logic [CTRL_W-1:0] m_done
);

  localparam int PW    = 2 * DATA_W;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  // Operand magnitude. Signed mode takes the two's-complement absolute value.
  // The most negative value maps onto itself, which is its correct magnitude
  // when the result is read as unsigned.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v);
    if (SIGNED != 0 && v[DATA_W-1]) return ~v + 1'b1;
    return v;
  endfunction

  // Reapply the sign that was stripped off by the sign-magnitude capture.
  function automatic logic [PW-1:0] finalise(input logic [PW-1:0] mag,
                                             input logic neg);
    if (neg) return ~mag + 1'b1;
    return mag;
  endfunction

  // Flags a product that does not fit in DATA_W bits. In signed mode the top
  // DATA_W+1 bits must all be sign copies.
  function automatic logic overflow_chk(input logic [PW-1:0] p);
    if (SIGNED != 0) return !((&p[PW-1:DATA_W-1]) || !(|p[PW-1:DATA_W-1]));
    return |p[PW-1:DATA_W];
  endfunction

  state_t              state_q, state_d;
  logic                start_q, start_d;
  logic                arm_q, arm_d;
  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [PW-1:0]       acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sign_q, sign_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic                busy_q, busy_d;

  logic                start_edge;
  logic [PW-1:0]       partial;
  logic [PW-1:0]       acc_sum;
  logic [PW-1:0]       product;
  logic                unused_ctrl;

  // The upper control bits carry no meaning for this block.
  assign unused_ctrl = ^{m_start[CTRL_W-1:1], m_reset[CTRL_W-1:1]};

  // arm_q is cleared only by the async reset. It is set once start has been
  // seen low. This keeps a start level held through reset from looking like
  // a fresh edge after release, because start_q itself resets to 0.
  assign start_edge = m_start[0] & ~start_q & arm_q;

  assign partial = mplier_q[0] ? ({{DATA_W{1'b0}}, mcand_q} << cnt_q) : '0;
  assign acc_sum = acc_q + partial;
  assign product = finalise(acc_sum, sign_q);

  always_comb begin
    state_d  = state_q;
    start_d  = m_start[0];
    arm_d    = arm_q | ~m_start[0];
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    result_d = result_q;
    done_d   = done_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;

    if (m_reset[0]) begin
      // Soft clear wins over everything, including a simultaneous start edge.
      state_d  = IDLE;
      acc_d    = '0;
      cnt_d    = '0;
      result_d = '0;
      done_d   = 1'b0;
      ovf_d    = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_edge) begin
            mcand_d  = magnitude(m_in1);
            mplier_d = magnitude(m_in2);
            sign_d   = (SIGNED != 0) ? (m_in1[DATA_W-1] ^ m_in2[DATA_W-1]) : 1'b0;
            acc_d    = '0;
            cnt_d    = '0;
            done_d   = 1'b0;
            ovf_d    = 1'b0;
            busy_d   = 1'b1;
            state_d  = RUN;
          end
        end
        RUN: begin
          acc_d    = acc_sum;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            // The last bit is folded in combinationally, so the product is
            // final at this edge.
            result_d = product[DATA_W-1:0];
            ovf_d    = overflow_chk(product);
            done_d   = 1'b1;
            busy_d   = 1'b0;
            cnt_d    = '0;
            state_d  = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q  <= IDLE;
      start_q  <= 1'b0;
      arm_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      arm_q    <= arm_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      result_q <= result_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
    end
  end

  assign m_result = result_q;
  assign m_done   = CTRL_W'({busy_q, ovf_q, done_q});

endmodule

// File: tb/tb_mult_core.sv
// Bench for mult_core. It runs an unsigned instance and a signed instance
// side by side on shared inputs, so every operation checks both modes.
module tb_mult_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] m_start, m_reset, m_in1, m_in2;
  logic [31:0] res_u, res_s, done_u, done_s;

  always #5 clk = ~clk;

  mult_core #(.DATA_W(32), .CTRL_W(32), .SIGNED(0)) dut_u (
    .clk_clk(clk), .reset_reset_n(rst_n), .m_start(m_start), .m_reset(m_reset),
    .m_in1(m_in1), .m_in2(m_in2), .m_result(res_u), .m_done(done_u));

  mult_core #(.DATA_W(32), .CTRL_W(32), .SIGNED(1)) dut_s (
    .clk_clk(clk), .reset_reset_n(rst_n), .m_start(m_start), .m_reset(m_reset),
    .m_in1(m_in1), .m_in2(m_in2), .m_result(res_s), .m_done(done_s));

  int checks = 0;
  int errors = 0;
  logic [31:0] prev_u, prev_s;

  typedef struct {
    logic [31:0] a, b;
    logic [31:0] ru, du, rs, ds;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: full-width arithmetic on the mathematical product.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                                output logic [31:0] r, output logic [31:0] d);
    longint      sa, sb, sp;
    logic [63:0] up;
    bit          ovf;
    if (sgn) begin
      sa  = $signed(a);
      sb  = $signed(b);
      sp  = sa * sb;
      r   = sp[31:0];
      ovf = (sp < -64'sd2147483648) || (sp > 64'sd2147483647);
    end else begin
      up  = {32'd0, a} * {32'd0, b};
      r   = up[31:0];
      ovf = |up[63:32];
    end
    d = ovf ? 32'h3 : 32'h1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eu, input logic [31:0] edu,
                        input logic [31:0] es, input logic [31:0] eds, input string tag);
    m_start = 32'd0;
    tick();
    m_in1 = a;
    m_in2 = b;
    m_start = 32'd1;
    tick();
    check({tag, " busy_u"}, done_u, 32'h4);
    check({tag, " busy_s"}, done_s, 32'h4);
    check({tag, " hold_u"}, res_u, prev_u);
    check({tag, " hold_s"}, res_s, prev_s);
    m_in1 = ~a;
    m_in2 = ~b;
    repeat (31) tick();
    check({tag, " late_busy_u"}, done_u, 32'h4);
    check({tag, " late_busy_s"}, done_s, 32'h4);
    tick();
    check({tag, " res_u"}, res_u, eu);
    check({tag, " done_u"}, done_u, edu);
    check({tag, " res_s"}, res_s, es);
    check({tag, " done_s"}, done_s, eds);
    prev_u = eu;
    prev_s = es;
  endtask

  initial begin
    vec_t        vecs[9];
    logic [31:0] ra, rb, eu, edu, es, eds;
    logic [31:0] ok;

    vecs[0] = '{32'd3,        32'd5,        32'h0000000F, 32'h1, 32'h0000000F, 32'h1};
    vecs[1] = '{32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 32'h3, 32'hFFFFFFFE, 32'h1};
    vecs[2] = '{32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 32'h3, 32'hFFFFFFEB, 32'h1};
    vecs[3] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h3, 32'h80000000, 32'h3};
    vecs[4] = '{32'd0,        32'hDEADBEEF, 32'h00000000, 32'h1, 32'h00000000, 32'h1};
    vecs[5] = '{32'h00010000, 32'h00010000, 32'h00000000, 32'h3, 32'h00000000, 32'h3};
    vecs[6] = '{32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, 32'h1, 32'hFFFE0001, 32'h3};
    vecs[7] = '{32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 32'h1, 32'h7FFFFFFF, 32'h1};
    vecs[8] = '{32'h80000000, 32'd1,        32'h80000000, 32'h1, 32'h80000000, 32'h1};

    rst_n = 1'b0;
    m_start = 32'd0;
    m_reset = 32'd0;
    m_in1 = 32'd0;
    m_in2 = 32'd0;
    prev_u = 32'd0;
    prev_s = 32'd0;
    repeat (3) tick();
    check("reset res_u", res_u, 32'd0);
    check("reset done_u", done_u, 32'd0);
    check("reset res_s", res_s, 32'd0);
    check("reset done_s", done_s, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].ru, vecs[i].du, vecs[i].rs, vecs[i].ds,
             $sformatf("vec%0d", i));

    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 1) ra = ra >> 20;
      if (i % 4 == 2) rb = rb >> 16;
      if (i % 4 == 3) begin ra = ra >> 18; rb = rb >> 18; end
      model(ra, rb, 1'b0, eu, edu);
      model(ra, rb, 1'b1, es, eds);
      run_op(ra, rb, eu, edu, es, eds, $sformatf("rnd%0d", i));
    end

    // Start toggle and operand change mid-run are ignored; held start gives one op.
    m_start = 32'd0;
    tick();
    m_in1 = 32'd7;
    m_in2 = 32'd6;
    m_start = 32'd1;
    tick();
    repeat (9) tick();
    m_start = 32'd0;
    m_in1 = 32'd9;
    tick();
    m_start = 32'd1;
    tick();
    repeat (20) tick();
    check("midrun busy", done_u, 32'h4);
    tick();
    check("midrun res_u", res_u, 32'd42);
    check("midrun done_u", done_u, 32'h1);
    check("midrun res_s", res_s, 32'd42);
    check("midrun done_s", done_s, 32'h1);
    ok = 32'd1;
    repeat (40) begin
      tick();
      if (done_u !== 32'h1 || res_u !== 32'd42 || done_s !== 32'h1 || res_s !== 32'd42) ok = 32'd0;
    end
    check("held start single op", ok, 32'd1);
    prev_u = 32'd42;
    prev_s = 32'd42;

    // Soft clear mid-run.
    m_start = 32'd0;
    tick();
    m_in1 = 32'd100;
    m_in2 = 32'd100;
    m_start = 32'd1;
    tick();
    repeat (14) tick();
    m_reset = 32'd1;
    tick();
    m_reset = 32'd0;
    check("softclr res_u", res_u, 32'd0);
    check("softclr done_u", done_u, 32'd0);
    check("softclr res_s", res_s, 32'd0);
    check("softclr done_s", done_s, 32'd0);
    ok = 32'd1;
    repeat (40) begin
      tick();
      if (done_u !== 32'd0 || done_s !== 32'd0) ok = 32'd0;
    end
    check("softclr no done", ok, 32'd1);
    prev_u = 32'd0;
    prev_s = 32'd0;
    run_op(32'd4, 32'd4, 32'd16, 32'h1, 32'd16, 32'h1, "after_softclr");

    // Soft clear beats a simultaneous start edge; held start after it never launches.
    m_start = 32'd0;
    tick();
    m_reset = 32'd1;
    m_start = 32'd1;
    tick();
    repeat (3) tick();
    check("clr_prio done", done_u, 32'd0);
    check("clr_prio res", res_u, 32'd0);
    m_reset = 32'd0;
    ok = 32'd1;
    repeat (40) begin
      tick();
      if (done_u !== 32'd0 || done_s !== 32'd0) ok = 32'd0;
    end
    check("clr_release no launch", ok, 32'd1);
    prev_u = 32'd0;
    prev_s = 32'd0;

    // Async reset mid-run with start held high.
    run_op(32'd5, 32'd5, 32'd25, 32'h1, 32'd25, 32'h1, "pre_async");
    m_start = 32'd0;
    tick();
    m_in1 = 32'd11;
    m_in2 = 32'd13;
    m_start = 32'd1;
    tick();
    repeat (20) tick();
    rst_n = 1'b0;
    #1;
    check("async res_u", res_u, 32'd0);
    check("async done_u", done_u, 32'd0);
    check("async res_s", res_s, 32'd0);
    check("async done_s", done_s, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    ok = 32'd1;
    repeat (40) begin
      tick();
      if (done_u !== 32'd0 || done_s !== 32'd0 || res_u !== 32'd0) ok = 32'd0;
    end
    check("async release no launch", ok, 32'd1);
    prev_u = 32'd0;
    prev_s = 32'd0;
    run_op(32'd11, 32'd13, 32'd143, 32'h1, 32'd143, 32'h1, "after_async");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_core.md
Name: mult_core

Overview:
- FPGA-side sequential multiplier that consumes the HPS multiplier conduits (m_start, m_reset, m_in1, m_in2) and produces m_result and m_done for the HPS to read back.
- Uses a radix-2 shift-add engine: one multiplier bit per clock, DATA_W iterations per operation.
- Sits directly downstream of the soc_system mult_control/mult_data conduits in the top-level wrapper.

Parameters:
- DATA_W, 32, operand and result width.
- CTRL_W, 32, width of the m_start, m_reset and m_done control words.
- SIGNED, 0: 0 = unsigned multiply; 1 = two's-complement multiply via sign-magnitude.

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  asynchronous, active-low reset.
- m_start  in  CTRL_W  bit0 = start request (level written by HPS; rising edge launches); other bits ignored.
- m_reset  in  CTRL_W  bit0 = synchronous soft clear; other bits ignored.
- m_in1  in  DATA_W  multiplicand.
- m_in2  in  DATA_W  multiplier.
- m_result  out  DATA_W  low DATA_W bits of the product, registered.
- m_done  out  CTRL_W  bit0 = done, bit1 = overflow, bit2 = busy; bits [CTRL_W-1:3] are always 0.

Behaviour:
- Async reset (reset_reset_n=0): state=IDLE, m_result=0, m_done=0, start_q=0, counter=0, accumulator=0.
- start_q registers m_start[0] every cycle, including during soft clear. A start edge is m_start[0]=1 and start_q=0 at a clock edge.
- A start held high through reset or soft clear does not launch an operation; a fresh 0->1 transition is required.
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE, on a start edge:
  - Capture |m_in1| into mcand and |m_in2| into mplier. The absolute value applies only when SIGNED=1; otherwise the raw value is captured.
  - Record sign = m_in1[MSB]^m_in2[MSB] (SIGNED=1 only).
  - Clear the 2*DATA_W accumulator; counter=0.
  - Set done=0, overflow=0, busy=1; state->RUN.
  - m_result keeps its previous value until the new operation completes.
- RUN, each cycle:
  - If mplier[0]=1, accumulator += mcand << counter.
  - mplier >>= 1; counter++.
- RUN exit: when counter reaches DATA_W-1 and that final bit is processed, at the same edge:
  - The product is finalised (negated if sign=1).
  - m_result = product[DATA_W-1:0].
  - done=1, busy=0, overflow set; state->DONE.
- Latency: done and the valid result are visible exactly DATA_W clock edges after the start-edge capture (32 cycles by default).
- Overflow:
  - Unsigned: 1 if product[2*DATA_W-1:DATA_W] != 0.
  - Signed: 1 if product is outside the range [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- DONE: m_result and m_done held stable indefinitely. A new start edge relaunches directly (DONE->RUN, done cleared at that edge).
- Start edges during RUN are ignored; the operation continues unaffected.
- m_in1/m_in2 changes after capture have no effect on the running operation.
- Soft clear (m_reset[0]=1 sampled at an edge), from any state:
  - state=IDLE, m_result=0, m_done=0, accumulator and counter cleared.
  - Has priority over a simultaneous start edge.
  - Holding m_reset[0] high keeps the block in IDLE.
- Reset mid-RUN (async or soft): the operation is abandoned, no done pulse is produced, and the outputs go to their reset values.
- Zero operand: the full DATA_W iterations still run. The result is 0, overflow=0, and latency is unchanged.

Test Plan:
- Unsigned: m_in1=3, m_in2=5, raise m_start[0] -> after 32 cycles m_result=0x0000000F, m_done=0x1; m_done=0x4 (busy) during the run.
- Overflow: m_in1=0xFFFFFFFF, m_in2=2 -> m_result=0xFFFFFFFE, m_done=0x3.
- Ignore start and operand changes mid-run: start 7*6; toggle m_start[0] and change m_in1 to 9 at cycle 10 -> m_result=42 at cycle 32; no second operation; a held-high start produces exactly one operation.
- Soft clear mid-run: start 100*100; assert m_reset[0] at cycle 15 for 1 cycle -> m_result=0, m_done=0, no done ever; a new start edge with 4*4 -> 16 after 32 cycles.
- Async reset mid-run: drop reset_reset_n at cycle 20 with m_start[0] held high -> outputs 0 immediately; after release, no launch until m_start[0] goes 0->1.
- SIGNED=1: m_in1=0xFFFFFFFD (-3), m_in2=7 -> m_result=0xFFFFFFEB, m_done=0x1. Then 0x80000000*0xFFFFFFFF -> m_result=0x80000000, m_done=0x3.
